shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift unit for the RV32 execute stage: accepts one SLL/SRL/SRA request, shifts by up to STEP bits per cycle
//  through a small chunk shifter, returns the result on a valid/ready response port.
//  Trades latency for area versus a full 32-way barrel shifter; sits beside the ALU and is sequenced by the pipeline control.
// PARAMETERS
//  XLEN  32  operand/result width
//  STEP  4   max bits shifted per cycle; power of 2, 1..XLEN
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     reset, asynchronous, active-high
//  flush      in   1     synchronous abort of in-flight operation
//  req_valid  in   1     request present
//  req_ready  out  1     unit can accept request
//  req_op     in   2     00 SLL, 01 SRL, 10 SRA, 11 reserved
//  req_a      in   XLEN  value to shift
//  req_b      in   XLEN  shift amount; only req_b[4:0] used (RV32I)
//  rsp_valid  out  1     result available
//  rsp_ready  in   1     consumer takes result
//  rsp_data   out  XLEN  shifted result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, rsp_valid 0, rsp_data 0, busy 0, remaining-amount 0; req_ready forced 0 while rst high.
//  FSM states IDLE, SHIFT, DONE.
//  - IDLE: req_ready = !flush. Accept on req_valid && req_ready: capture a, op, amt=req_b[4:0], sign=req_a[XLEN-1].
//    amt==0 or op==11 -> DONE with rsp_data=a; else -> SHIFT.
//  - SHIFT: each cycle shift working reg by s=min(amt_rem, STEP), amt_rem -= s.
//    SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills MSBs with captured sign. amt_rem reaches 0 -> DONE.
//  - DONE: rsp_valid=1, rsp_data and rsp_valid held stable until rsp_valid && rsp_ready, then -> IDLE.
//  Latency: rsp_valid asserted 1+ceil(amt/STEP) cycles after accept edge (amt 0 or op 11: 1 cycle).
//  Throughput: one request in flight; req_ready only in IDLE; at least one IDLE cycle between operations.
//  rsp_data only changes on accept (amt 0 path) or SHIFT cycles; not cleared on response handshake.
//  flush: any state -> IDLE on next edge; rsp_valid drops, no response for aborted op.
//    flush wins over simultaneous req_valid (not accepted) and over rsp_ready in DONE (treated as discarded).
//  Result width: all arithmetic modulo XLEN; amt range 0..31, no out-of-range case.
//  No combinational path from req_* to rsp_*; rsp_valid and rsp_data are registered.
// STRUCTURE
//  shift_pkg: op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSV), FSM state encoding, XLEN, SHAMT_W=5.
//  Sub-module shift_step: combinational chunk shifter (in, op, sign, s[log2(STEP):0]) -> out, s in 0..STEP.
//  Top holds FSM, working reg, amt_rem counter, handshake logic.
// TESTING (XLEN=32, STEP=4)
//  SRL a=0x8000_0000 b=31 -> rsp_data 0x0000_0001, rsp_valid 9 cycles after accept.
//  SRA a=0x8000_0000 b=4 -> 0xF800_0000 after 2 cycles; SRA a=0x7FFF_FFFF b=31 -> 0x0000_0000.
//  SLL a=0x1234_5678 b=0 -> 0x1234_5678 after 1 cycle; b=0x24 (uses 4) -> 0x2345_6780 after 2 cycles.
//  Backpressure: rsp_ready low 5 cycles in DONE -> rsp_valid/data held, req_ready 0, queued req accepted after handshake+IDLE.
//  flush in 3rd SHIFT cycle of SRL b=20 -> no rsp_valid, IDLE next cycle; following SLL a=1 b=1 -> 0x2.
//  rst asserted mid-SHIFT between edges -> rsp_valid, busy, rsp_data 0 immediately; req_ready 0 until rst drops.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STEP_DEF = 4;
    localparam int unsigned SHAMT_W  = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bus between pipeline control and the shift sequencer.
interface shift_sequencer_if;
    import shift_sequencer_pkg::*;

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    op_e             req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            busy;

    modport master (
        output flush, req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  flush, req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational chunk shifter: shifts by s (0..STEP) bits in one cycle.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned STEP = STEP_DEF
) (
    input  logic [XLEN-1:0]        din,
    input  op_e                    op,
    input  logic                   sign,
    input  logic [$clog2(STEP):0]  s,
    output logic [XLEN-1:0]        dout_c
);

    logic [XLEN-1:0] fill;

    always_comb begin
        fill   = sign ? ~({XLEN{1'b1}} >> s) : '0;
        dout_c = din;
        unique case (op)
            OP_SLL:  dout_c = din << s;
            OP_SRL:  dout_c = din >> s;
            OP_SRA:  dout_c = (din >> s) | fill;
            default: dout_c = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle RV32 shift unit: up to STEP bits per cycle, valid/ready response.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned STEP = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);

    localparam int unsigned S_W = $clog2(STEP) + 1;

    state_e             state;
    op_e                op_q;
    logic               sign_q;
    logic [XLEN-1:0]    work;
    logic [SHAMT_W-1:0] amt_rem;
    logic               rsp_valid_q;
    logic [XLEN-1:0]    rsp_data_q;

    logic [S_W-1:0]     step_s;
    logic [SHAMT_W-1:0] amt_next;
    logic [XLEN-1:0]    step_out;
    logic [SHAMT_W-1:0] req_amt;

    // Chunk size for this cycle: min(remaining, STEP).
    always_comb begin
        step_s   = (32'(amt_rem) > STEP) ? S_W'(STEP) : S_W'(amt_rem);
        amt_next = amt_rem - SHAMT_W'(step_s);
        req_amt  = bus.req_b[SHAMT_W-1:0];
    end

    shift_step #(.STEP(STEP)) u_step (
        .din    (work),
        .op     (op_q),
        .sign   (sign_q),
        .s      (step_s),
        .dout_c (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_SLL;
            sign_q      <= 1'b0;
            work        <= '0;
            amt_rem     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (bus.flush) begin
            // Abort wins over any accept or response handshake this cycle.
            state       <= ST_IDLE;
            amt_rem     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        sign_q <= bus.req_a[XLEN-1];
                        work   <= bus.req_a;
                        if (req_amt == '0 || bus.req_op == OP_RSV) begin
                            rsp_data_q  <= bus.req_a;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            amt_rem <= req_amt;
                            state   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work       <= step_out;
                    rsp_data_q <= step_out;
                    amt_rem    <= amt_next;
                    if (amt_next == '0) begin
                        rsp_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE) && !bus.flush && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule
